// File: rtl/amba_axi4_lite_slave_regs_if.sv
// AXI4-Lite channel bundle between a bus master and the register-bank slave.
// Clock and reset travel as plain ports beside it.
interface amba_axi4_lite_slave_regs_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                     AWVALID;
    logic                     AWREADY;
    logic [ADDRESS_WIDTH-1:0] AWADDR;
    logic [2:0]               AWPROT;
    logic                     WVALID;
    logic                     WREADY;
    logic [DATA_WIDTH-1:0]    WDATA;
    logic [STRB_WIDTH-1:0]    WSTRB;
    logic                     BVALID;
    logic                     BREADY;
    logic [1:0]               BRESP;
    logic                     ARVALID;
    logic                     ARREADY;
    logic [ADDRESS_WIDTH-1:0] ARADDR;
    logic [2:0]               ARPROT;
    logic                     RVALID;
    logic                     RREADY;
    logic [DATA_WIDTH-1:0]    RDATA;
    logic [1:0]               RRESP;

    modport master (
        output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/amba_axi4_lite_slave_regs.sv
// AXI4-Lite register bank: NUM_REGS byte-strobed registers, one outstanding
// read and one outstanding write, contents exported flat on reg_out.
module amba_axi4_lite_slave_regs #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGS      = 16
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    amba_axi4_lite_slave_regs_if.slave     s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_LSB    = $clog2(STRB_WIDTH);
    localparam int IDX_W      = $clog2(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  rdy_en;
    logic                  aw_held;
    logic                  w_held;
    logic [IDX_W-1:0]      aw_idx;
    logic                  aw_oor;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic [IDX_W-1:0]      ar_idx;
    logic                  ar_oor;
    logic                  unused_ok;

    assign s_axi.AWREADY = rdy_en & ~aw_held & ~s_axi.BVALID;
    assign s_axi.WREADY  = rdy_en & ~w_held & ~s_axi.BVALID;
    assign s_axi.ARREADY = rdy_en & ~s_axi.RVALID;

    assign aw_hs = s_axi.AWVALID & s_axi.AWREADY;
    assign w_hs  = s_axi.WVALID & s_axi.WREADY;
    assign ar_hs = s_axi.ARVALID & s_axi.ARREADY;

    // Any set bit above the index field selects a non-existent register.
    assign ar_idx = s_axi.ARADDR[IDX_LSB +: IDX_W];
    assign ar_oor = |(s_axi.ARADDR >> (IDX_LSB + IDX_W));

    assign unused_ok = ^{s_axi.AWPROT, s_axi.ARPROT,
                         s_axi.AWADDR[IDX_LSB-1:0], s_axi.ARADDR[IDX_LSB-1:0]};

    // Write path: AW and W latch independently; commit once both are held.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rdy_en       <= 1'b0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_idx       <= '0;
            aw_oor       <= 1'b0;
            w_data       <= '0;
            w_strb       <= '0;
            s_axi.BVALID <= 1'b0;
            s_axi.BRESP  <= RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            rdy_en <= 1'b1;
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_idx  <= s_axi.AWADDR[IDX_LSB +: IDX_W];
                aw_oor  <= |(s_axi.AWADDR >> (IDX_LSB + IDX_W));
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s_axi.WDATA;
                w_strb <= s_axi.WSTRB;
            end
            if (aw_held && w_held) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                s_axi.BVALID <= 1'b1;
                s_axi.BRESP  <= aw_oor ? RESP_SLVERR : RESP_OKAY;
                if (!aw_oor) begin
                    for (int k = 0; k < STRB_WIDTH; k++) begin
                        if (w_strb[k]) begin
                            regs[aw_idx][k*8 +: 8] <= w_data[k*8 +: 8];
                        end
                    end
                end
            end else if (s_axi.BVALID && s_axi.BREADY) begin
                s_axi.BVALID <= 1'b0;
            end
        end
    end

    // Read path: regs sampled at the AR edge, so a same-edge commit is not seen.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            s_axi.RVALID <= 1'b0;
            s_axi.RDATA  <= '0;
            s_axi.RRESP  <= RESP_OKAY;
        end else if (ar_hs) begin
            s_axi.RVALID <= 1'b1;
            s_axi.RDATA  <= ar_oor ? '0 : regs[ar_idx];
            s_axi.RRESP  <= ar_oor ? RESP_SLVERR : RESP_OKAY;
        end else if (s_axi.RVALID && s_axi.RREADY) begin
            s_axi.RVALID <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end
endmodule

// File: tb/tb_amba_axi4_lite_slave_regs.sv
// Directed bench for the AXI4-Lite register bank: reset, latency, strobes,
// out-of-range, read stall, read/write collision and mid-transaction reset.
module tb_amba_axi4_lite_slave_regs;
    logic         ACLK = 1'b0;
    logic         ARESETn = 1'b0;
    logic [511:0] reg_out;
    int           total = 0;
    int           bad = 0;

    amba_axi4_lite_slave_regs_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) m ();

    amba_axi4_lite_slave_regs #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .s_axi(m), .reg_out(reg_out)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] regv(input int i);
        return reg_out[i*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle_inputs();
        m.AWVALID = 1'b0; m.AWADDR = '0; m.AWPROT = '0;
        m.WVALID = 1'b0; m.WDATA = '0; m.WSTRB = '0; m.BREADY = 1'b0;
        m.ARVALID = 1'b0; m.ARADDR = '0; m.ARPROT = '0; m.RREADY = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done, w_done, aw_now, w_now;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        m.AWADDR = addr; m.AWVALID = 1'b1;
        m.WDATA = data; m.WSTRB = strb; m.WVALID = 1'b1; m.BREADY = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_now = m.AWREADY; w_now = m.WREADY;
            tick(); n++;
            if (aw_now) begin aw_done = 1; m.AWVALID = 1'b0; end
            if (w_now) begin w_done = 1; m.WVALID = 1'b0; end
        end
        m.AWVALID = 1'b0; m.WVALID = 1'b0;
        n = 0;
        while (!m.BVALID && n < 20) begin tick(); n++; end
        total++;
        if (m.BVALID !== 1'b1) begin bad++; $display("FAIL wr_timeout addr=%h got bvalid=%b exp=1", addr, m.BVALID); end
        resp = m.BRESP;
        tick();
        m.BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        m.ARADDR = addr; m.ARVALID = 1'b1; m.RREADY = 1'b1;
        n = 0;
        while (!m.ARREADY && n < 20) begin tick(); n++; end
        tick();
        m.ARVALID = 1'b0;
        n = 0;
        while (!m.RVALID && n < 20) begin tick(); n++; end
        total++;
        if (m.RVALID !== 1'b1) begin bad++; $display("FAIL rd_timeout addr=%h got rvalid=%b exp=1", addr, m.RVALID); end
        data = m.RDATA; resp = m.RRESP;
        tick();
        m.RREADY = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        ARESETn = 1'b0;
        repeat (3) tick();
        total++; if (reg_out !== '0) begin bad++; $display("FAIL rst_regout got=%h exp=0", reg_out); end
        ARESETn = 1'b1;
        total++; if ({m.AWREADY, m.WREADY, m.ARREADY} !== 3'b000) begin bad++; $display("FAIL rst_ready_first got=%b exp=000", {m.AWREADY, m.WREADY, m.ARREADY}); end
        total++; if ({m.BVALID, m.RVALID, m.BRESP, m.RRESP} !== 6'b0) begin bad++; $display("FAIL rst_valids got=%b exp=0", {m.BVALID, m.RVALID, m.BRESP, m.RRESP}); end
        total++; if (m.RDATA !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", m.RDATA); end
        tick();
        total++; if ({m.AWREADY, m.WREADY, m.ARREADY} !== 3'b111) begin bad++; $display("FAIL rst_ready_second got=%b exp=111", {m.AWREADY, m.WREADY, m.ARREADY}); end
    endtask

    task automatic test_latency();
        m.AWADDR = 32'h04; m.AWVALID = 1'b1; m.BREADY = 1'b1;
        tick();
        m.AWVALID = 1'b0;
        total++; if ({m.AWREADY, m.WREADY} !== 2'b01) begin bad++; $display("FAIL lat_ready_c4 got=%b exp=01", {m.AWREADY, m.WREADY}); end
        tick();
        total++; if ({m.AWREADY, m.WREADY, m.BVALID} !== 3'b010) begin bad++; $display("FAIL lat_ready_c5 got=%b exp=010", {m.AWREADY, m.WREADY, m.BVALID}); end
        m.WDATA = 32'hDEADBEEF; m.WSTRB = 4'hF; m.WVALID = 1'b1;
        tick();
        m.WVALID = 1'b0;
        total++; if (m.BVALID !== 1'b0) begin bad++; $display("FAIL lat_bvalid_c6 got=%b exp=0", m.BVALID); end
        total++; if (regv(1) !== 32'h0) begin bad++; $display("FAIL lat_reg1_c6 got=%h exp=0", regv(1)); end
        tick();
        total++; if ({m.BVALID, m.BRESP} !== 3'b100) begin bad++; $display("FAIL lat_b_c7 got=%b exp=100", {m.BVALID, m.BRESP}); end
        total++; if (regv(1) !== 32'hDEADBEEF) begin bad++; $display("FAIL lat_reg1_c7 got=%h exp=deadbeef", regv(1)); end
        total++; if ({m.AWREADY, m.WREADY} !== 2'b00) begin bad++; $display("FAIL lat_ready_c7 got=%b exp=00", {m.AWREADY, m.WREADY}); end
        tick();
        total++; if (m.BVALID !== 1'b0) begin bad++; $display("FAIL lat_bvalid_c8 got=%b exp=0", m.BVALID); end
        m.BREADY = 1'b0;
    endtask

    task automatic test_strobe();
        logic [1:0] resp;
        logic [31:0] data;
        axi_write(32'h08, 32'h11223344, 4'hF, resp);
        axi_write(32'h08, 32'hAABBCCDD, 4'h5, resp);
        total++; if (resp !== 2'b00) begin bad++; $display("FAIL strb_bresp got=%0d exp=0", resp); end
        total++; if (regv(2) !== 32'h11BB33DD) begin bad++; $display("FAIL strb_reg2 got=%h exp=11bb33dd", regv(2)); end
        axi_read(32'h08, data, resp);
        total++; if ({data, resp} !== {32'h11BB33DD, 2'b00}) begin bad++; $display("FAIL strb_read got=%h/%0d exp=11bb33dd/0", data, resp); end
        axi_write(32'h08, 32'hFFFFFFFF, 4'h0, resp);
        total++; if ({regv(2), resp} !== {32'h11BB33DD, 2'b00}) begin bad++; $display("FAIL strb_zero got=%h/%0d exp=11bb33dd/0", regv(2), resp); end
        axi_read(32'h0B, data, resp);
        total++; if (data !== 32'h11BB33DD) begin bad++; $display("FAIL strb_lowbits got=%h exp=11bb33dd", data); end
        axi_write(32'h3C, 32'hCAFEF00D, 4'hF, resp);
        axi_read(32'h3C, data, resp);
        total++; if ({data, resp, regv(15)} !== {32'hCAFEF00D, 2'b00, 32'hCAFEF00D}) begin bad++; $display("FAIL strb_reg15 got=%h/%0d exp=cafef00d/0", data, resp); end
    endtask

    task automatic test_oor();
        logic [511:0] snap;
        logic [1:0] resp;
        logic [31:0] data;
        snap = reg_out;
        axi_write(32'h40, 32'hFFFFFFFF, 4'hF, resp);
        total++; if (resp !== 2'b10) begin bad++; $display("FAIL oor_bresp got=%0d exp=2", resp); end
        total++; if (reg_out !== snap) begin bad++; $display("FAIL oor_regout changed got=%h", reg_out); end
        axi_read(32'h100, data, resp);
        total++; if ({data, resp} !== {32'h0, 2'b10}) begin bad++; $display("FAIL oor_read got=%h/%0d exp=0/2", data, resp); end
    endtask

    task automatic test_read_stall();
        m.ARADDR = 32'h04; m.ARVALID = 1'b1; m.RREADY = 1'b0;
        tick();
        m.ARADDR = 32'h08;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({m.RVALID, m.RDATA, m.RRESP, m.ARREADY} !== {1'b1, 32'hDEADBEEF, 2'b00, 1'b0}) begin
                bad++; $display("FAIL stall_c%0d got v=%b d=%h r=%0d ar=%b exp v=1 d=deadbeef r=0 ar=0", i, m.RVALID, m.RDATA, m.RRESP, m.ARREADY);
            end
            tick();
        end
        m.RREADY = 1'b1;
        tick();
        total++; if ({m.RVALID, m.ARREADY} !== 2'b01) begin bad++; $display("FAIL stall_release got=%b exp=01", {m.RVALID, m.ARREADY}); end
        tick();
        m.ARVALID = 1'b0;
        total++; if ({m.RVALID, m.RDATA} !== {1'b1, 32'h11BB33DD}) begin bad++; $display("FAIL stall_next got=%b/%h exp=1/11bb33dd", m.RVALID, m.RDATA); end
        tick();
        m.RREADY = 1'b0;
        total++; if (m.RVALID !== 1'b0) begin bad++; $display("FAIL stall_done got=%b exp=0", m.RVALID); end
    endtask

    task automatic test_collision();
        logic [1:0] resp;
        axi_write(32'h0C, 32'h12345678, 4'hF, resp);
        m.AWADDR = 32'h0C; m.AWVALID = 1'b1;
        m.WDATA = 32'h9ABCDEF0; m.WSTRB = 4'hF; m.WVALID = 1'b1;
        tick();
        m.AWVALID = 1'b0; m.WVALID = 1'b0;
        m.ARADDR = 32'h0C; m.ARVALID = 1'b1;
        tick();
        m.ARVALID = 1'b0;
        total++; if ({m.RVALID, m.RDATA} !== {1'b1, 32'h12345678}) begin bad++; $display("FAIL coll_rdata got=%b/%h exp=1/12345678", m.RVALID, m.RDATA); end
        total++; if ({m.BVALID, regv(3)} !== {1'b1, 32'h9ABCDEF0}) begin bad++; $display("FAIL coll_write got=%b/%h exp=1/9abcdef0", m.BVALID, regv(3)); end
        m.BREADY = 1'b1; m.RREADY = 1'b1;
        tick();
        total++; if ({m.BVALID, m.RVALID} !== 2'b00) begin bad++; $display("FAIL coll_done got=%b exp=00", {m.BVALID, m.RVALID}); end
        m.BREADY = 1'b0; m.RREADY = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp;
        logic [31:0] data;
        m.AWADDR = 32'h14; m.AWVALID = 1'b1;
        m.WDATA = 32'h00000055; m.WSTRB = 4'hF; m.WVALID = 1'b1;
        m.ARADDR = 32'h04; m.ARVALID = 1'b1;
        tick();
        m.AWVALID = 1'b0; m.WVALID = 1'b0; m.ARVALID = 1'b0;
        tick();
        total++; if ({m.BVALID, m.RVALID, regv(5)} !== {2'b11, 32'h55}) begin bad++; $display("FAIL mid_pending got=%b/%h exp=11/55", {m.BVALID, m.RVALID}, regv(5)); end
        #3 ARESETn = 1'b0;
        #1;
        total++; if ({m.BVALID, m.RVALID} !== 2'b00) begin bad++; $display("FAIL mid_async_valids got=%b exp=00", {m.BVALID, m.RVALID}); end
        total++; if (reg_out !== '0) begin bad++; $display("FAIL mid_async_regs got=%h exp=0", reg_out); end
        tick();
        ARESETn = 1'b1;
        tick();
        m.AWADDR = 32'h10; m.AWVALID = 1'b1;
        tick();
        m.AWVALID = 1'b0;
        #3 ARESETn = 1'b0;
        #1;
        total++; if (m.AWREADY !== 1'b0) begin bad++; $display("FAIL mid_awready got=%b exp=0", m.AWREADY); end
        tick();
        ARESETn = 1'b1;
        tick();
        m.WDATA = 32'h00000077; m.WSTRB = 4'hF; m.WVALID = 1'b1;
        tick();
        m.WVALID = 1'b0;
        repeat (3) tick();
        total++; if ({m.BVALID, regv(4)} !== {1'b0, 32'h0}) begin bad++; $display("FAIL mid_dropped_aw got=%b/%h exp=0/0", m.BVALID, regv(4)); end
        m.AWADDR = 32'h10; m.AWVALID = 1'b1;
        tick();
        m.AWVALID = 1'b0;
        tick();
        total++; if ({m.BVALID, m.BRESP, regv(4)} !== {3'b100, 32'h77}) begin bad++; $display("FAIL mid_resume got=%b/%h exp=100/77", {m.BVALID, m.BRESP}, regv(4)); end
        m.BREADY = 1'b1;
        tick();
        m.BREADY = 1'b0;
        axi_write(32'h10, 32'hA5A5A5A5, 4'hF, resp);
        axi_read(32'h10, data, resp);
        total++; if ({data, resp} !== {32'hA5A5A5A5, 2'b00}) begin bad++; $display("FAIL mid_fresh got=%h/%0d exp=a5a5a5a5/0", data, resp); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_strobe();
        test_oor();
        test_read_stall();
        test_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
